rv_writeback: RTL
=================

RV_WRITEBACK -- requirements
Module: rv_writeback

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports are named per codebase convention as clk_i and rst_n_i.
REQ-002 clk_i  in  1  core clock; all state updates on rising edge.
REQ-003 rst_n_i  in  1  asynchronous active-low reset.
REQ-004 w_fun_i  in  3  load width/sign code (LDST_B=000, LDST_H=001, LDST_L=010, LDST_BU=100, LDST_HU=101).
REQ-005 w_load_i  in  1  one-cycle pulse: load issued by execute stage this cycle.
REQ-006 w_store_i  in  1  store issued; never produces a register write.
REQ-007 w_rd_i  in  5  destination register index.
REQ-008 w_rd_value_i  in  32  ALU/jump result from execute stage.
REQ-009 w_rd_write_i  in  1  ALU-result write request, valid for one cycle.
REQ-010 w_dm_addr_i  in  32  load/store byte address.
REQ-011 dm_data_l_i  in  32  data memory read data, valid when dm_load_done_i=1.
REQ-012 dm_load_done_i  in  1  load data return strobe.
REQ-013 rf_rd_o  out  5  register file write index.
REQ-014 rf_rd_value_o  out  32  register file write data.
REQ-015 rf_rd_write_o  out  1  register file write enable, one-cycle pulse.
REQ-016 w_stall_req_o  out  1  stall request to execute stage.
REQ-017 w_misaligned_o  out  1  one-cycle pulse: misaligned load dropped.
REQ-018 w_bus_error_o  out  1  one-cycle pulse: load timed out.
REQ-019 Parameter LOAD_TIMEOUT, default 255, maximum wait cycles for dm_load_done_i (8-bit counter).

Function
REQ-020 rf_* outputs SHALL be registered: a write accepted in cycle N appears on rf_* in cycle N+1.
REQ-021 FSM states IDLE and WAIT_LOAD; reset state IDLE.
REQ-022 IDLE, w_rd_write_i=1 and w_load_i=0: SHALL register rd/value; rf_rd_write_o=1 next cycle.
REQ-023 IDLE, w_load_i=1, dm_load_done_i=1 same cycle: SHALL write aligned data next cycle, remain IDLE, no stall.
REQ-024 IDLE, w_load_i=1, dm_load_done_i=0: SHALL latch rd, fun, addr[1:0], enter WAIT_LOAD, clear timeout counter.
REQ-025 w_stall_req_o SHALL be combinationally 1 in WAIT_LOAD and 0 in IDLE.
REQ-026 WAIT_LOAD, dm_load_done_i=1: SHALL write aligned data from latched fields next cycle and return to IDLE.
REQ-027 WAIT_LOAD, counter reaches LOAD_TIMEOUT without done: SHALL pulse w_bus_error_o, perform no write, return to IDLE.
REQ-028 WAIT_LOAD: w_load_i, w_rd_write_i, w_store_i SHALL be ignored; late dm_load_done_i after timeout is ignored in IDLE when no load is pending.
REQ-029 Alignment: B/BU select byte addr[1:0], H/HU select halfword addr[1]; sign-extend for B/H, zero-extend for BU/HU; L passes the word.
REQ-030 H/HU with addr[0]=1, or L with addr[1:0]!=0: SHALL drop the write and pulse w_misaligned_o when data returns; undefined fun codes are treated the same.
REQ-031 rd=0 SHALL never assert rf_rd_write_o, for ALU results or loads.
REQ-032 w_store_i SHALL cause no state change and no write.

Reset
REQ-033 On rst_n_i=0, FSM goes to IDLE immediately; all outputs, the counter and latched fields go to 0, including mid-WAIT_LOAD; a pending load is discarded.
REQ-034 First write after reset release SHALL be possible on the first rising edge with rst_n_i=1.

Structure
REQ-035 LDST_* codes and FSM state encodings SHALL reside in the shared rv_defs definitions.
REQ-036 Alignment/extension logic SHALL be a combinational sub-module rv_load_align (inputs fun, addr[1:0], data; outputs value, misaligned).

Verification
REQ-037 ALU write: w_rd_write_i=1, rd=5, value=0x12345678 -> next cycle rf_rd_o=5, rf_rd_value_o=0x12345678, rf_rd_write_o=1 for 1 cycle.
REQ-038 LB, addr=0x1003, same-cycle done, data=0x80FFFFFF -> rf_rd_value_o=0xFFFFFF80; LBU same -> 0x00000080; no stall.
REQ-039 LH, addr=0x2002, done after 3 cycles, data=0xBEEF0000 -> w_stall_req_o=1 for 3 cycles, then rf_rd_value_o=0xFFFFBEEF.
REQ-040 LW, addr=0x2001 -> w_misaligned_o pulse, rf_rd_write_o stays 0.
REQ-041 Load, no done for 255 cycles -> w_bus_error_o pulse, return to IDLE, stall drops; rd=0 load with data 0xFFFFFFFF -> no write.
REQ-042 rst_n_i low during WAIT_LOAD -> w_stall_req_o=0 immediately, no later write when done arrives.

Source files
------------

// File: rtl/rv_defs_pkg.sv
// Shared writeback definitions: load width/sign codes, FSM encoding and the
// record kept for a load that is still waiting on data memory.
package rv_defs_pkg;

  typedef enum logic [2:0] {
    LDST_B  = 3'b000,
    LDST_H  = 3'b001,
    LDST_L  = 3'b010,
    LDST_BU = 3'b100,
    LDST_HU = 3'b101
  } ldst_e;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] fun;
    logic [1:0] addr;
  } ld_pend_t;

endpackage

// File: rtl/rv_load_align.sv
// Load data alignment and sign/zero extension; flags misaligned or unknown loads.
module rv_load_align
  import rv_defs_pkg::*;
(
  input  logic [2:0]  fun,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [31:0] value,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = data[8*addr +: 8];
  assign half_sel = addr[1] ? data[31:16] : data[15:0];

  always_comb begin
    value      = '0;
    misaligned = 1'b0;
    case (ldst_e'(fun))
      LDST_B:  value = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: value = {24'h0, byte_sel};
      LDST_H: begin
        value      = {{16{half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      LDST_HU: begin
        value      = {16'h0, half_sel};
        misaligned = addr[0];
      end
      LDST_L: begin
        value      = data;
        misaligned = (addr != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_writeback.sv
// Writeback stage: registers ALU results and load data into the register file,
// stalling execute while a load waits on data memory, with a bounded timeout.
module rv_writeback
  import rv_defs_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [2:0]  w_fun_i,
  input  logic        w_load_i,
  input  logic        w_store_i,
  input  logic [4:0]  w_rd_i,
  input  logic [31:0] w_rd_value_i,
  input  logic        w_rd_write_i,
  input  logic [31:0] w_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic        w_stall_req_o,
  output logic        w_misaligned_o,
  output logic        w_bus_error_o
);

  localparam logic [7:0] TO_LAST = 8'(LOAD_TIMEOUT - 1);

  wb_state_e   state;
  ld_pend_t    pend;
  logic [7:0]  cnt;

  logic        waiting;
  logic [4:0]  al_rd;
  logic [2:0]  al_fun;
  logic [1:0]  al_addr;
  logic [31:0] al_value;
  logic        al_mis;
  logic        ld_fire;

  assign waiting       = (state == WB_WAIT_LOAD);
  assign w_stall_req_o = waiting;

  // While waiting, the latched fields describe the load; otherwise the live inputs do.
  assign al_rd   = waiting ? pend.rd   : w_rd_i;
  assign al_fun  = waiting ? pend.fun  : w_fun_i;
  assign al_addr = waiting ? pend.addr : w_dm_addr_i[1:0];
  assign ld_fire = dm_load_done_i && (waiting || w_load_i);

  rv_load_align u_align (
    .fun        (al_fun),
    .addr       (al_addr),
    .data       (dm_data_l_i),
    .value      (al_value),
    .misaligned (al_mis)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= WB_IDLE;
      pend           <= '0;
      cnt            <= '0;
      rf_rd_o        <= '0;
      rf_rd_value_o  <= '0;
      rf_rd_write_o  <= 1'b0;
      w_misaligned_o <= 1'b0;
      w_bus_error_o  <= 1'b0;
    end else begin
      rf_rd_write_o  <= 1'b0;
      w_misaligned_o <= 1'b0;
      w_bus_error_o  <= 1'b0;
      if (ld_fire) begin
        state <= WB_IDLE;
        if (al_mis) begin
          w_misaligned_o <= 1'b1;
        end else begin
          rf_rd_o       <= al_rd;
          rf_rd_value_o <= al_value;
          rf_rd_write_o <= (al_rd != 5'd0);
        end
      end else if (!waiting) begin
        if (w_load_i) begin
          state <= WB_WAIT_LOAD;
          pend  <= '{rd: w_rd_i, fun: w_fun_i, addr: w_dm_addr_i[1:0]};
          cnt   <= '0;
        end else if (w_rd_write_i && !w_store_i) begin
          rf_rd_o       <= w_rd_i;
          rf_rd_value_o <= w_rd_value_i;
          rf_rd_write_o <= (w_rd_i != 5'd0);
        end
      end else if (cnt == TO_LAST) begin
        w_bus_error_o <= 1'b1;
        state         <= WB_IDLE;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule
